// File: rtl/count_match_pkg.sv
// Shared types and sizing for the count/match controller and its datapath.
package count_match_pkg;

  localparam int WIDTH = 8;

  typedef enum logic [1:0] {IDLE, CLEAR, COUNT, DONE} state_e;

endpackage

// File: rtl/count_match_if.sv
// Request/result handshake bundle between a request source/result consumer and the controller.
interface count_match_if;
  import count_match_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_target;
  logic             abort;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_count;
  logic             out_aborted;
  logic             busy;

  modport master (
    output in_valid, in_target, abort, out_ready,
    input  in_ready, out_valid, out_count, out_aborted, busy
  );

  modport slave (
    input  in_valid, in_target, abort, out_ready,
    output in_ready, out_valid, out_count, out_aborted, busy
  );

endinterface

// File: rtl/count_match_dp.sv
// Counter register, equality comparator and result register steered by the controller FSM.
module count_match_dp
  import count_match_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic             load_result,
  input  logic             set_aborted,
  input  logic [WIDTH-1:0] target,
  output logic             eq,
  output logic [WIDTH-1:0] result_count,
  output logic             result_aborted
);

  logic [WIDTH-1:0] counter;

  assign eq = (counter == target);

  // The result captures the counter value from before this edge's update.
  always_ff @(posedge clk) begin
    if (rst) begin
      counter        <= '0;
      result_count   <= '0;
      result_aborted <= 1'b0;
    end else begin
      if (clr) begin
        counter        <= '0;
        result_aborted <= 1'b0;
      end else if (inc) begin
        counter <= counter + 1'b1;
      end
      if (load_result) begin
        result_count   <= counter;
        result_aborted <= set_aborted;
      end
    end
  end

endmodule

// File: rtl/count_match_ctrl.sv
// Sequencing FSM: accepts a target, runs the counter up to it (or until abort), then holds the result.
module count_match_ctrl
  import count_match_pkg::*;
(
  input logic         clk,
  input logic         rst,
  count_match_if.slave bus
);

  state_e           state;
  logic [WIDTH-1:0] target_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;
  logic             running;
  logic             clr;
  logic             inc;
  logic             load_result;
  logic             set_aborted;
  logic             eq;

  // Abort wins over both the match and the increment while a run is active.
  assign running     = (state == CLEAR) || (state == COUNT);
  assign set_aborted = running && bus.abort;
  assign clr         = (state == CLEAR) && !bus.abort;
  assign inc         = (state == COUNT) && !bus.abort && !eq;
  assign load_result = set_aborted || ((state == COUNT) && eq);

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;

  count_match_dp u_dp (
    .clk            (clk),
    .rst            (rst),
    .clr            (clr),
    .inc            (inc),
    .load_result    (load_result),
    .set_aborted    (set_aborted),
    .target         (target_q),
    .eq             (eq),
    .result_count   (bus.out_count),
    .result_aborted (bus.out_aborted)
  );

  // in_ready is held low during reset and rises in the first cycle after release.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      target_q    <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (bus.in_valid && in_ready_q) begin
            state      <= CLEAR;
            target_q   <= bus.in_target;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        CLEAR, COUNT: begin
          if (load_result) begin
            state       <= DONE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
          end else if (state == CLEAR) begin
            state <= COUNT;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
